// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//   Bank of NCH independent programmable clock dividers, all running on
//   clock_in. Each channel produces a registered divided clock whose period
//   and high-phase length are set at run time, plus a one-cycle tick at the
//   start of every period. New settings are staged on a load strobe and take
//   effect only at a period boundary (or straight away while the channel is
//   disabled), so a running output never sees a truncated period.
//
// Parameters
//   NCH      number of channels (1..8)
//   CW       width of counter, divisor and high count
//   DEF_DIV  divisor used after reset; high count defaults to DEF_DIV/2
//
// Ports
//   clock_in   in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   [NCH]      per-channel run enable
//   load       in   [NCH]      per-channel strobe capturing divisor/high_cnt
//   divisor    in   [NCH*CW]   channel i period, bits [i*CW +: CW]
//   high_cnt   in   [NCH*CW]   channel i high-phase length, same packing
//   clock_out  out  [NCH]      registered divided clocks
//   tick       out  [NCH]      registered period-start pulses
//   pending    out  [NCH]      staged settings awaiting a period boundary
module clock_divider_multi #(
  parameter int NCH     = 2,
  parameter int CW      = 25,
  parameter int DEF_DIV = 1000
) (
  input  logic              clock_in,
  input  logic              rst_n,
  input  logic [NCH-1:0]    enable,
  input  logic [NCH-1:0]    load,
  input  logic [NCH*CW-1:0] divisor,
  input  logic [NCH*CW-1:0] high_cnt,
  output logic [NCH-1:0]    clock_out,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    pending
);

  localparam logic [CW-1:0] DEF_D = CW'(DEF_DIV);
  localparam logic [CW-1:0] DEF_H = CW'(DEF_DIV / 2);
  localparam logic [CW-1:0] MIN_D = CW'(2);
  localparam logic [CW-1:0] ONE   = CW'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] act_div;
    logic [CW-1:0] act_high;
    logic [CW-1:0] stg_div;
    logic [CW-1:0] stg_high;
    logic          pend;
    logic          clk_q;
    logic          tick_q;

    logic [CW-1:0] raw_div;
    logic [CW-1:0] in_div;
    logic [CW-1:0] in_high;
    logic          boundary;
    logic          apply;

    assign raw_div  = divisor[i*CW +: CW];
    // A divisor of 0 or 1 cannot produce a two-phase clock; clamp to 2.
    assign in_div   = (raw_div < MIN_D) ? MIN_D : raw_div;
    assign in_high  = high_cnt[i*CW +: CW];

    assign boundary = enable[i] && (cnt == act_div - ONE);
    // Settings may take effect at the end of a period, or at any time while
    // the channel is idle since there is no period in flight to disturb.
    assign apply    = boundary || !enable[i];

    always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= '0;
        act_div  <= DEF_D;
        act_high <= DEF_H;
        stg_div  <= DEF_D;
        stg_high <= DEF_H;
        pend     <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        if (enable[i]) begin
          cnt <= boundary ? '0 : cnt + ONE;
        end else begin
          cnt <= '0;
        end

        clk_q  <= enable[i] && (cnt < act_high);
        tick_q <= enable[i] && (cnt == '0);

        if (load[i]) begin
          stg_div  <= in_div;
          stg_high <= in_high;
        end

        // A load coinciding with an apply point bypasses staging, so the
        // freshly presented values win over any older staged ones.
        if (apply) begin
          if (load[i]) begin
            act_div  <= in_div;
            act_high <= in_high;
          end else if (pend) begin
            act_div  <= stg_div;
            act_high <= stg_high;
          end
          pend <= 1'b0;
        end else if (load[i]) begin
          pend <= 1'b1;
        end
      end
    end

    assign clock_out[i] = clk_q;
    assign tick[i]      = tick_q;
    assign pending[i]   = pend;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

  localparam int NCH = 2;
  localparam int CW  = 25;
  localparam int DEF = 1000;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    enable;
  logic [NCH-1:0]    load;
  logic [NCH*CW-1:0] divisor;
  logic [NCH*CW-1:0] high_cnt;
  logic [NCH-1:0]    clock_out;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    pending;

  int checks   = 0;
  int failures = 0;

  clock_divider_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF)) dut (
    .clock_in (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .load     (load),
    .divisor  (divisor),
    .high_cnt (high_cnt),
    .clock_out(clock_out),
    .tick     (tick),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    en;
    logic [1:0]    ld;
    logic [CW-1:0] d0;
    logic [CW-1:0] h0;
    logic [CW-1:0] d1;
    logic [CW-1:0] h1;
    logic [1:0]    clk;
    logic [1:0]    tk;
    logic [1:0]    pd;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Channel 0 entry; channel 1 fields are filled in afterwards.
  task automatic add0(input logic en, input logic ld, input int d, input int h,
                      input logic c, input logic t, input logic p);
    vec_t v;
    v.en  = {1'b0, en};
    v.ld  = {1'b0, ld};
    v.d0  = CW'(d);
    v.h0  = CW'(h);
    v.d1  = '0;
    v.h1  = '0;
    v.clk = {1'b0, c};
    v.tk  = {1'b0, t};
    v.pd  = {1'b0, p};
    tbl.push_back(v);
  endtask

  // Reset-default waveform on both channels: high 500, low 500, tick every 1000.
  task automatic check_def(input int ncyc, input string tag);
    logic [1:0] ec;
    logic [1:0] et;
    for (int n = 1; n <= ncyc; n++) begin
      step();
      ec = (((n - 1) % DEF) < (DEF / 2)) ? 2'b11 : 2'b00;
      et = (((n - 1) % DEF) == 0) ? 2'b11 : 2'b00;
      chk($sformatf("%s_clk[%0d]", tag, n), clock_out, ec);
      chk($sformatf("%s_tick[%0d]", tag, n), tick, et);
      chk($sformatf("%s_pend[%0d]", tag, n), pending, 2'b00);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int c1;

    rst_n    = 1'b0;
    enable   = '0;
    load     = '0;
    divisor  = '0;
    high_cnt = '0;

    // ---- Channel 0 vectors (en, ld, div, high, exp clk, exp tick, exp pend)
    add0(0, 1, 4, 2, 0, 0, 0);  // 1  load 4/2 while idle -> active at once
    add0(1, 0, 0, 0, 1, 1, 0);  // 2
    add0(1, 0, 0, 0, 1, 0, 0);  // 3
    add0(1, 0, 0, 0, 0, 0, 0);  // 4
    add0(1, 0, 0, 0, 0, 0, 0);  // 5  boundary
    add0(1, 0, 0, 0, 1, 1, 0);  // 6
    add0(1, 1, 6, 3, 1, 0, 1);  // 7  load 6/3 at cnt=1 -> staged
    add0(1, 0, 0, 0, 0, 0, 1);  // 8
    add0(1, 0, 0, 0, 0, 0, 0);  // 9  boundary applies 6/3
    add0(1, 0, 0, 0, 1, 1, 0);  // 10
    add0(1, 0, 0, 0, 1, 0, 0);  // 11
    add0(1, 0, 0, 0, 1, 0, 0);  // 12
    add0(1, 0, 0, 0, 0, 0, 0);  // 13
    add0(1, 0, 0, 0, 0, 0, 0);  // 14
    add0(1, 1, 3, 1, 0, 0, 0);  // 15 load 3/1 on boundary, no pending
    add0(1, 0, 0, 0, 1, 1, 0);  // 16
    add0(1, 0, 0, 0, 0, 0, 0);  // 17
    add0(1, 0, 0, 0, 0, 0, 0);  // 18
    add0(1, 0, 0, 0, 1, 1, 0);  // 19
    add0(1, 0, 0, 0, 0, 0, 0);  // 20
    add0(1, 1, 1, 1, 0, 0, 0);  // 21 divisor 1 on boundary -> 2
    add0(1, 0, 0, 0, 1, 1, 0);  // 22
    add0(1, 1, 4, 0, 0, 0, 0);  // 23 boundary; load 4/0
    add0(1, 0, 0, 0, 0, 1, 0);  // 24 high=0: clock stays 0, tick continues
    add0(1, 0, 0, 0, 0, 0, 0);  // 25
    add0(1, 0, 0, 0, 0, 0, 0);  // 26
    add0(1, 1, 5, 9, 0, 0, 0);  // 27 boundary; load 5/9
    add0(1, 0, 0, 0, 1, 1, 0);  // 28 high>=div: stuck 1
    add0(1, 0, 0, 0, 1, 0, 0);  // 29
    add0(1, 0, 0, 0, 1, 0, 0);  // 30
    add0(1, 0, 0, 0, 1, 0, 0);  // 31
    add0(1, 1, 4, 3, 1, 0, 0);  // 32 boundary; load 4/3
    add0(1, 0, 0, 0, 1, 1, 0);  // 33
    add0(1, 0, 0, 0, 1, 0, 0);  // 34
    add0(0, 0, 0, 0, 0, 0, 0);  // 35 enable drop at cnt=2
    add0(0, 0, 0, 0, 0, 0, 0);  // 36
    add0(1, 0, 0, 0, 1, 1, 0);  // 37 full period restarts
    add0(1, 0, 0, 0, 1, 0, 0);  // 38
    add0(1, 0, 0, 0, 1, 0, 0);  // 39
    add0(1, 0, 0, 0, 0, 0, 0);  // 40
    add0(1, 0, 0, 0, 1, 1, 0);  // 41

    // ---- Channel 1: 3/2 loaded idle at vector 1, enabled from vector 2,
    // 5/1 loaded at vector 20 (cnt=0, staged), applied at boundary vector 22.
    for (int i = 0; i < tbl.size(); i++) begin
      n = i + 1;
      tbl[i].en[1] = (n >= 2);
      if (n == 1) begin
        tbl[i].ld[1] = 1'b1;
        tbl[i].d1    = CW'(3);
        tbl[i].h1    = CW'(2);
      end
      if (n == 20) begin
        tbl[i].ld[1] = 1'b1;
        tbl[i].d1    = CW'(5);
        tbl[i].h1    = CW'(1);
      end
      if (n == 1) begin
        tbl[i].clk[1] = 1'b0;
        tbl[i].tk[1]  = 1'b0;
        tbl[i].pd[1]  = 1'b0;
      end else if (n <= 22) begin
        c1 = (n - 2) % 3;
        tbl[i].clk[1] = (c1 < 2);
        tbl[i].tk[1]  = (c1 == 0);
        tbl[i].pd[1]  = (n == 20 || n == 21);
      end else begin
        c1 = (n - 23) % 5;
        tbl[i].clk[1] = (c1 == 0);
        tbl[i].tk[1]  = (c1 == 0);
        tbl[i].pd[1]  = 1'b0;
      end
    end

    // ---- Reset held: outputs all low
    repeat (3) step();
    chk("rst_hold_clk", clock_out, 2'b00);
    chk("rst_hold_tick", tick, 2'b00);
    chk("rst_hold_pend", pending, 2'b00);

    // ---- Reset defaults on both channels
    rst_n  = 1'b1;
    enable = 2'b11;
    check_def(2000, "def");

    // ---- Directed table
    foreach (tbl[i]) begin
      enable   = tbl[i].en;
      load     = tbl[i].ld;
      divisor  = {tbl[i].d1, tbl[i].d0};
      high_cnt = {tbl[i].h1, tbl[i].h0};
      step();
      chk($sformatf("v%0d_clk", i + 1), clock_out, tbl[i].clk);
      chk($sformatf("v%0d_tick", i + 1), tick, tbl[i].tk);
      chk($sformatf("v%0d_pend", i + 1), pending, tbl[i].pd);
    end
    load = '0;

    // ---- Pending load then reset at cnt=2 (ch0 on 4/3, ch1 on 5/1 at cnt=1)
    enable   = 2'b11;
    load     = 2'b01;
    divisor  = {CW'(0), CW'(8)};
    high_cnt = {CW'(0), CW'(4)};
    step();
    load = '0;
    chk("preset_clk", clock_out, 2'b01);
    chk("preset_tick", tick, 2'b00);
    chk("preset_pend", pending, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk", clock_out, 2'b00);
    chk("async_rst_tick", tick, 2'b00);
    chk("async_rst_pend", pending, 2'b00);
    step();
    step();
    rst_n = 1'b1;
    check_def(1000, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
